// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter that shares the register-file write port among NUM_REQ writeback sources.
// Optional macro RF_WB_BYPASS_EN adds two read-port forwarding muxes driven from the registered write.
module rf_wb_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      wb_stall,
  output logic                      RegWrite,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic [IDX_W-1:0]          grant_idx
`ifdef RF_WB_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0]         rd_addr1,
  input  logic [ADDR_W-1:0]         rd_addr2,
  input  logic [DATA_W-1:0]         rf_rd_data1,
  input  logic [DATA_W-1:0]         rf_rd_data2,
  output logic [DATA_W-1:0]         fwd_data1,
  output logic [DATA_W-1:0]         fwd_data2
`endif
);

  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  gnt;
  logic              xfer;
  logic [IDX_W-1:0]  ptr_next;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  int unsigned       idx;

  // Scan ptr, ptr+1, ... and take the first valid source; ready is held low in reset and on stall.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    req_ready = '0;
    gnt       = '0;
    xfer      = 1'b0;
    idx       = 0;
    if (rst && !wb_stall) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (int'(ptr) + k) % NUM_REQ;
        if (!xfer && req_valid[IDX_W'(idx)]) begin
          xfer = 1'b1;
          gnt  = IDX_W'(idx);
        end
      end
      if (xfer) req_ready[gnt] = 1'b1;
    end
  end

  always_comb begin
    sel_addr = req_addr[int'(gnt)*ADDR_W +: ADDR_W];
    sel_data = req_data[int'(gnt)*DATA_W +: DATA_W];
    ptr_next = (gnt == IDX_W'(NUM_REQ-1)) ? '0 : gnt + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr       <= '0;
      RegWrite  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      grant_idx <= '0;
    end else if (xfer) begin
      ptr       <= ptr_next;
      RegWrite  <= |sel_addr;  // x0 writes are consumed but never issued
      wr_addr   <= sel_addr;
      wr_data   <= sel_data;
      grant_idx <= gnt;
    end else begin
      RegWrite  <= 1'b0;
    end
  end

`ifdef RF_WB_BYPASS_EN
  always_comb begin
    fwd_data1 = rf_rd_data1;
    fwd_data2 = rf_rd_data2;
    if (RegWrite && (rd_addr1 != '0) && (rd_addr1 == wr_addr)) fwd_data1 = wr_data;
    if (RegWrite && (rd_addr2 != '0) && (rd_addr2 == wr_addr)) fwd_data2 = wr_data;
  end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter with NUM_REQ=2.
// Forwarding checks are compiled in when RF_WB_BYPASS_EN is defined.
module tb_rf_wb_arbiter;
  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [ADDR_W-1:0] a0, a1;
  logic [DATA_W-1:0] d0, d1;
  logic              wb_stall;
  logic              RegWrite;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [0:0]        grant_idx;
`ifdef RF_WB_BYPASS_EN
  logic [ADDR_W-1:0] rd_addr1, rd_addr2;
  logic [DATA_W-1:0] rf_rd_data1, rf_rd_data2, fwd_data1, fwd_data2;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  ({a1, a0}),
    .req_data  ({d1, d0}),
    .wb_stall  (wb_stall),
    .RegWrite  (RegWrite),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .grant_idx (grant_idx)
`ifdef RF_WB_BYPASS_EN
    ,
    .rd_addr1    (rd_addr1),
    .rd_addr2    (rd_addr2),
    .rf_rd_data1 (rf_rd_data1),
    .rf_rd_data2 (rf_rd_data2),
    .fwd_data1   (fwd_data1),
    .fwd_data2   (fwd_data2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; req_valid = '0; wb_stall = 1'b0;
    a0 = '0; a1 = '0; d0 = '0; d1 = '0;
`ifdef RF_WB_BYPASS_EN
    rd_addr1 = '0; rd_addr2 = '0; rf_rd_data1 = '0; rf_rd_data2 = '0;
`endif
    // Reset held for three cycles; ready must stay low even with a valid request.
    tick(); tick();
    req_valid = 2'b01;
    #1 check("ready_in_reset", 32'(req_ready), 32'h0);
    req_valid = 2'b00;
    tick();
    check("rst_regwrite", 32'(RegWrite), 32'h0);
    check("rst_wr_addr", 32'(wr_addr), 32'h0);
    check("rst_wr_data", wr_data, 32'h0);
    check("rst_grant_idx", 32'(grant_idx), 32'h0);
    @(negedge clk) rst = 1'b1;

    // Idle after release.
    for (int c = 0; c < 2; c++) begin
      tick();
      check("idle_regwrite", 32'(RegWrite), 32'h0);
      check("idle_ready", 32'(req_ready), 32'h0);
      check("idle_wr_addr", 32'(wr_addr), 32'h0);
      check("idle_wr_data", wr_data, 32'h0);
    end

    // Single source 0 for one cycle; ptr becomes 1.
    req_valid = 2'b01; a0 = 5'd5; d0 = 32'hDEADBEEF;
    #1 check("single_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b00;
    check("single_regwrite", 32'(RegWrite), 32'h1);
    check("single_wr_addr", 32'(wr_addr), 32'h5);
    check("single_wr_data", wr_data, 32'hDEADBEEF);
    check("single_grant_idx", 32'(grant_idx), 32'h0);
    tick();
    check("single_regwrite_drop", 32'(RegWrite), 32'h0);
    check("single_wr_addr_hold", 32'(wr_addr), 32'h5);

    // x0 write from source 1: accepted, never issued; ptr returns to 0.
    req_valid = 2'b10; a1 = 5'd0; d1 = 32'hAA;
    #1 check("x0_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = 2'b00;
    check("x0_regwrite", 32'(RegWrite), 32'h0);
    check("x0_grant_idx", 32'(grant_idx), 32'h1);
    check("x0_wr_data", wr_data, 32'hAA);

    // Contention from ptr=0: grants alternate 0,1,0,1.
    req_valid = 2'b11; a0 = 5'd1; d0 = 32'h11; a1 = 5'd2; d1 = 32'h22;
    for (int c = 0; c < 4; c++) begin
      #1 check("cont_ready", 32'(req_ready), (c % 2 == 0) ? 32'h1 : 32'h2);
      tick();
      check("cont_regwrite", 32'(RegWrite), 32'h1);
      check("cont_wr_addr", 32'(wr_addr), (c % 2 == 0) ? 32'h1 : 32'h2);
      check("cont_wr_data", wr_data, (c % 2 == 0) ? 32'h11 : 32'h22);
      check("cont_grant_idx", 32'(grant_idx), 32'(c % 2));
    end

    // Stall with both valid: no grants, pointer must stay at 0.
    wb_stall = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1 check("stall_ready", 32'(req_ready), 32'h0);
      tick();
      check("stall_regwrite", 32'(RegWrite), 32'h0);
    end
    wb_stall = 1'b0;
    #1 check("post_stall_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b00;
    check("post_stall_wr_addr", 32'(wr_addr), 32'h1);
    check("post_stall_grant_idx", 32'(grant_idx), 32'h0);

`ifdef RF_WB_BYPASS_EN
    req_valid = 2'b01; a0 = 5'd7; d0 = 32'h1234;
    tick();
    req_valid = 2'b00;
    rd_addr1 = 5'd7; rf_rd_data1 = 32'h0; rd_addr2 = 5'd8; rf_rd_data2 = 32'h55;
    #1 check("fwd_hit", fwd_data1, 32'h1234);
    check("fwd_miss", fwd_data2, 32'h55);
    tick();
`endif

    // Async reset in the cycle after a handshake (ptr is 1 beforehand).
    req_valid = 2'b01; a0 = 5'd9; d0 = 32'h99;
    tick();
    req_valid = 2'b00;
    check("flight_regwrite", 32'(RegWrite), 32'h1);
    #2 rst = 1'b0;
    #1 check("async_regwrite", 32'(RegWrite), 32'h0);
    check("async_wr_addr", 32'(wr_addr), 32'h0);
    @(negedge clk) rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      check("post_rst_regwrite", 32'(RegWrite), 32'h0);
    end
    req_valid = 2'b11;
    #1 check("post_rst_ptr", 32'(req_ready), 32'h1);
    req_valid = 2'b00;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
